multi_snoop_cache_unit: RTL and testbench
=========================================

// Module: multi_snoop_cache_unit
// PURPOSE
// - Set-associative tag/state/data store for the snoopy invalidate-protocol cache. Serves one CPU-controller port and NUM_SNOOP_PORTS snoop ports.
// - Adds true-LRU victim selection and a sequential flush (invalidate-all) engine.
// - Sits between the CPU/snoopy controllers and the per-way arrays. Single clock domain.
// PARAMETERS
// TAG_WIDTH          6      tag bits
// INDEX_WIDTH        6      set index bits (2**INDEX_WIDTH sets)
// OFFSET_WIDTH       4      word offset bits within a line
// SET_ASSOCIATIVITY  2      log2 of way count (default: 4 ways)
// DATA_WIDTH         16     word width
// STATE_WIDTH        2      coherence state bits
// INVALID_STATE      2'b00  encoding of the invalid state
// NUM_SNOOP_PORTS    2      number of independent snoop lookup/update ports
// PORTS (S = NUM_SNOOP_PORTS; snoop buses are packed [S-1:0][w-1:0])
// clock             in   1             single clock, rising edge
// reset             in   1             asynchronous, active-high
// cpuIndex          in   INDEX_WIDTH   set select
// cpuOffset         in   OFFSET_WIDTH  word select
// cpuTagIn          in   TAG_WIDTH     lookup / write tag
// cpuDataIn         in   DATA_WIDTH    write data
// cpuStateIn        in   STATE_WIDTH   write state
// cpuWriteTag       in   1             write tag into way cpuCacheNumber
// cpuWriteData      in   1             write word into way cpuCacheNumber
// cpuWriteState     in   1             write state into way cpuCacheNumber
// cpuAccess         in   1             touch way cpuCacheNumber in LRU
// cpuTagOut         out  TAG_WIDTH     tag of way cpuCacheNumber
// cpuDataOut        out  DATA_WIDTH    word of way cpuCacheNumber
// cpuStateOut       out  STATE_WIDTH   state of way cpuCacheNumber
// cpuCacheNumber    out  SET_ASSOCIATIVITY  hit way, else victim way
// cpuHit            out  1             tag match on a non-invalid way
// snoopyIndex       in   S*INDEX_WIDTH
// snoopyOffset      in   S*OFFSET_WIDTH
// snoopyTagIn       in   S*TAG_WIDTH
// snoopyStateIn     in   S*STATE_WIDTH
// snoopyWriteState  in   S             write state into the port's hit way (ignored on miss)
// snoopyDataOut     out  S*DATA_WIDTH
// snoopyStateOut    out  S*STATE_WIDTH
// snoopyCacheNumber out  S*SET_ASSOCIATIVITY
// snoopyHit         out  S
// flushRequest      in   1             start invalidate-all
// flushBusy         out  1             flush in progress
// BEHAVIOUR
// - Reset (async): every state <= INVALID_STATE; LRU age of way w <= w in every set; flush FSM to IDLE; flushBusy = 0.
//   Tag/data arrays are not reset. Outputs are combinational from the arrays, so after reset cpuHit = snoopyHit = 0 and cpuCacheNumber = 0.
// - Lookups are combinational, 0-cycle latency; all array writes commit on the rising clock edge.
// - cpuCacheNumber: hit way if hit. On miss: lowest-numbered invalid way; if none, the way with age 2**SET_ASSOCIATIVITY-1.
// - LRU: on cpuAccess, touched way age <= 0. Ways with age < the old age of the touched way increment; others hold.
//   Ages stay a permutation of 0..WAYS-1. Snoop accesses never update LRU.
// - Invalid-state writes do not change ages.
// - Write conflicts on the same set and way in one cycle:
//   - Any snoop state write beats the CPU state write.
//   - The lowest-numbered snoop port beats higher ports.
//   - CPU tag/data writes still commit.
// - Flush FSM, IDLE -> WALK -> IDLE:
//   - flushRequest in IDLE: next edge enters WALK with counter 0, flushBusy = 1.
//   - Each WALK cycle invalidates all ways of set[counter] and resets its ages.
//   - Counter wraps at 2**INDEX_WIDTH-1, then returns to IDLE: flushBusy high exactly 2**INDEX_WIDTH cycles.
//   - flushRequest during WALK is ignored.
//   - While busy: cpuHit forced 0, CPU writes and cpuAccess ignored. Snoop lookups proceed; snoop state writes are ignored (flush wins).
//   - Reset mid-walk aborts to IDLE.
// STRUCTURE
// - Shared package cache_unit_pkg: flush_state_t enum {IDLE, WALK}, lru age typedef, INVALID_STATE default constant.
// - Sub-module lru_set_tracker: per-set age vector, touch logic, and victim select (invalid mask in, way out), instantiated once per set.
// TESTING (default parameters)
// 1) After reset, look up index 5, tag 0x2A -> cpuHit=0, cpuCacheNumber=0. Write tag/data 0x1234/state 2'b01, then access -> same lookup hits way 0, cpuDataOut=0x1234.
// 2) Fill ways 0..3 of set 7 and access in order 0,1,2,3; then access way 0. A miss on a new tag -> cpuCacheNumber=1.
// 3) Snoop port 1 hits set 7 way 2 with state 2'b00 while the CPU writes state 2'b11 to the same way in the same cycle -> state becomes INVALID, and that line's CPU lookup misses.
// 4) Ports 0 and 1 both write set 3 way 1 with states 2'b10 and 2'b01 -> stored 2'b10.
// 5) Pulse flushRequest with valid lines in sets 0 and 63 -> flushBusy high 64 cycles. A CPU write mid-flush is dropped, and all lookups miss afterwards.
// 6) Assert reset at flush cycle 10 -> flushBusy=0 immediately, all states INVALID, and a new flushRequest restarts from set 0.

Source files
------------

// File: rtl/multi_snoop_cache_unit_pkg.sv
// Shared types and defaults for the snoopy set-associative cache store.
package cache_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } flush_state_t;

  localparam int LRU_AGE_WIDTH = 2;
  typedef logic [LRU_AGE_WIDTH-1:0] lru_age_t;

  localparam logic [1:0] INVALID_STATE_DEFAULT = 2'b00;

endpackage

// File: rtl/multi_snoop_cache_unit_if.sv
// CPU-port, snoop-port and flush-control bundle of the cache store.
interface multi_snoop_cache_unit_if #(
  parameter int TAG_WIDTH         = 6,
  parameter int INDEX_WIDTH       = 6,
  parameter int OFFSET_WIDTH      = 4,
  parameter int SET_ASSOCIATIVITY = 2,
  parameter int DATA_WIDTH        = 16,
  parameter int STATE_WIDTH       = 2,
  parameter int NUM_SNOOP_PORTS   = 2
);
  import cache_unit_pkg::*;

  // There is no valid/ready pair: lookups are combinational and every write strobe
  // commits at the next rising edge. flush_request is sampled only while flush_busy
  // is low; once flush_busy rises it stays high for one cycle per set.
  logic [INDEX_WIDTH-1:0]       cpu_index;
  logic [OFFSET_WIDTH-1:0]      cpu_offset;
  logic [TAG_WIDTH-1:0]         cpu_tag_in;
  logic [DATA_WIDTH-1:0]        cpu_data_in;
  logic [STATE_WIDTH-1:0]       cpu_state_in;
  logic                         cpu_write_tag;
  logic                         cpu_write_data;
  logic                         cpu_write_state;
  logic                         cpu_access;
  logic [TAG_WIDTH-1:0]         cpu_tag_out;
  logic [DATA_WIDTH-1:0]        cpu_data_out;
  logic [STATE_WIDTH-1:0]       cpu_state_out;
  logic [SET_ASSOCIATIVITY-1:0] cpu_cache_number;
  logic                         cpu_hit;

  logic [NUM_SNOOP_PORTS-1:0][INDEX_WIDTH-1:0]       snoop_index;
  logic [NUM_SNOOP_PORTS-1:0][OFFSET_WIDTH-1:0]      snoop_offset;
  logic [NUM_SNOOP_PORTS-1:0][TAG_WIDTH-1:0]         snoop_tag_in;
  logic [NUM_SNOOP_PORTS-1:0][STATE_WIDTH-1:0]       snoop_state_in;
  logic [NUM_SNOOP_PORTS-1:0]                        snoop_write_state;
  logic [NUM_SNOOP_PORTS-1:0][DATA_WIDTH-1:0]        snoop_data_out;
  logic [NUM_SNOOP_PORTS-1:0][STATE_WIDTH-1:0]       snoop_state_out;
  logic [NUM_SNOOP_PORTS-1:0][SET_ASSOCIATIVITY-1:0] snoop_cache_number;
  logic [NUM_SNOOP_PORTS-1:0]                        snoop_hit;

  logic                   flush_request;
  logic                   flush_busy;
  flush_state_t           flush_state;
  logic [INDEX_WIDTH-1:0] flush_set;

  modport master (
    output cpu_index, cpu_offset, cpu_tag_in, cpu_data_in, cpu_state_in,
           cpu_write_tag, cpu_write_data, cpu_write_state, cpu_access,
           snoop_index, snoop_offset, snoop_tag_in, snoop_state_in, snoop_write_state,
           flush_request,
    input  cpu_tag_out, cpu_data_out, cpu_state_out, cpu_cache_number, cpu_hit,
           snoop_data_out, snoop_state_out, snoop_cache_number, snoop_hit,
           flush_busy, flush_state, flush_set
  );

  modport slave (
    input  cpu_index, cpu_offset, cpu_tag_in, cpu_data_in, cpu_state_in,
           cpu_write_tag, cpu_write_data, cpu_write_state, cpu_access,
           snoop_index, snoop_offset, snoop_tag_in, snoop_state_in, snoop_write_state,
           flush_request,
    output cpu_tag_out, cpu_data_out, cpu_state_out, cpu_cache_number, cpu_hit,
           snoop_data_out, snoop_state_out, snoop_cache_number, snoop_hit,
           flush_busy, flush_state, flush_set
  );

endinterface

// File: rtl/multi_snoop_cache_unit_lru_set_tracker.sv
// True-LRU age vector for one set: touch, clear, and victim selection.
module lru_set_tracker #(
  parameter int WAY_BITS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       touch,
  input  logic [WAY_BITS-1:0]        touch_way,
  input  logic                       clear,
  input  logic [(1<<WAY_BITS)-1:0]   invalid_mask,
  output logic [WAY_BITS-1:0]        victim
);
  localparam int WAYS = 1 << WAY_BITS;

  logic [WAY_BITS-1:0] age [WAYS];
  logic [WAY_BITS-1:0] touched_age;
  logic                any_invalid;

  assign touched_age = age[touch_way];
  assign any_invalid = |invalid_mask;

  // Ages form a permutation of 0..WAYS-1; way w starts (and restarts) at age w.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) age[w] <= WAY_BITS'(w);
    end else if (clear) begin
      for (int w = 0; w < WAYS; w++) age[w] <= WAY_BITS'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_BITS'(w) == touch_way) age[w] <= '0;
        else if (age[w] < touched_age) age[w] <= age[w] + 1'b1;
      end
    end
  end

  // Descending scan so the lowest qualifying way is the one left in victim.
  always_comb begin
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (any_invalid ? invalid_mask[w] : (age[w] == '1)) victim = WAY_BITS'(w);
    end
  end

endmodule

// File: rtl/multi_snoop_cache_unit.sv
// Tag/state/data store with one CPU port, snoop ports, true-LRU and a flush walker.
module multi_snoop_cache_unit
  import cache_unit_pkg::*;
#(
  parameter int TAG_WIDTH         = 6,
  parameter int INDEX_WIDTH       = 6,
  parameter int OFFSET_WIDTH      = 4,
  parameter int SET_ASSOCIATIVITY = 2,
  parameter int DATA_WIDTH        = 16,
  parameter int STATE_WIDTH       = 2,
  parameter logic [STATE_WIDTH-1:0] INVALID_STATE = STATE_WIDTH'(INVALID_STATE_DEFAULT),
  parameter int NUM_SNOOP_PORTS   = 2
) (
  input logic clk,
  input logic rst,
  multi_snoop_cache_unit_if.slave bus
);
  localparam int WAYS  = 1 << SET_ASSOCIATIVITY;
  localparam int SETS  = 1 << INDEX_WIDTH;
  localparam int WORDS = 1 << OFFSET_WIDTH;
  localparam int SA    = SET_ASSOCIATIVITY;

  logic [TAG_WIDTH-1:0]   tag_mem   [SETS][WAYS];
  logic [DATA_WIDTH-1:0]  data_mem  [SETS][WAYS][WORDS];
  logic [STATE_WIDTH-1:0] state_mem [SETS][WAYS];

  flush_state_t           state_q, state_d;
  logic [INDEX_WIDTH-1:0] count_q, count_d;
  logic                   busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (bus.flush_request) begin
        state_d = WALK;
        count_d = '0;
      end
      WALK: if (count_q == '1) state_d = IDLE;
            else count_d = count_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q == WALK);
    bus.flush_busy  = busy;
    bus.flush_state = state_q;
    bus.flush_set   = count_q;
  end

  logic [WAYS-1:0] invalid_mask [SETS];
  logic [SA-1:0]   victim_way   [SETS];
  logic [WAYS-1:0] cpu_match;
  logic [SA-1:0]   hit_way, cpu_way;
  logic            cpu_hit;

  always_comb begin
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        invalid_mask[s][w] = (state_mem[s][w] == INVALID_STATE);
  end

  always_comb begin
    cpu_match = '0;
    hit_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      cpu_match[w] = !invalid_mask[bus.cpu_index][w] &&
                     (tag_mem[bus.cpu_index][w] == bus.cpu_tag_in);
      if (cpu_match[w]) hit_way = SA'(w);
    end
  end

  // A walk in progress hides every CPU hit, so the CPU sees victims only.
  assign cpu_hit = (|cpu_match) && !busy;
  assign cpu_way = cpu_hit ? hit_way : victim_way[bus.cpu_index];

  assign bus.cpu_hit          = cpu_hit;
  assign bus.cpu_cache_number = cpu_way;
  assign bus.cpu_tag_out      = tag_mem[bus.cpu_index][cpu_way];
  assign bus.cpu_state_out    = state_mem[bus.cpu_index][cpu_way];
  assign bus.cpu_data_out     = data_mem[bus.cpu_index][cpu_way][bus.cpu_offset];

  for (genvar s = 0; s < SETS; s++) begin : g_lru
    lru_set_tracker #(.WAY_BITS(SA)) u_lru (
      .clk          (clk),
      .rst          (rst),
      .touch        (bus.cpu_access && !busy && (bus.cpu_index == INDEX_WIDTH'(s))),
      .touch_way    (cpu_way),
      .clear        (busy && (count_q == INDEX_WIDTH'(s))),
      .invalid_mask (invalid_mask[s]),
      .victim       (victim_way[s])
    );
  end

  logic [NUM_SNOOP_PORTS-1:0]         snoop_hit;
  logic [NUM_SNOOP_PORTS-1:0][SA-1:0] snoop_way;

  always_comb begin
    snoop_hit           = '0;
    snoop_way           = '0;
    bus.snoop_data_out  = '0;
    bus.snoop_state_out = '0;
    for (int p = 0; p < NUM_SNOOP_PORTS; p++) begin
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!invalid_mask[bus.snoop_index[p]][w] &&
            (tag_mem[bus.snoop_index[p]][w] == bus.snoop_tag_in[p])) begin
          snoop_hit[p] = 1'b1;
          snoop_way[p] = SA'(w);
        end
      end
      bus.snoop_data_out[p]  = data_mem[bus.snoop_index[p]][snoop_way[p]][bus.snoop_offset[p]];
      bus.snoop_state_out[p] = state_mem[bus.snoop_index[p]][snoop_way[p]];
    end
  end

  assign bus.snoop_hit          = snoop_hit;
  assign bus.snoop_cache_number = snoop_way;

  // Later assignments win: CPU first, then snoop ports from highest to lowest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) state_mem[s][w] <= INVALID_STATE;
    end else if (busy) begin
      for (int w = 0; w < WAYS; w++) state_mem[count_q][w] <= INVALID_STATE;
    end else begin
      if (bus.cpu_write_state) state_mem[bus.cpu_index][cpu_way] <= bus.cpu_state_in;
      for (int p = NUM_SNOOP_PORTS - 1; p >= 0; p--) begin
        if (bus.snoop_write_state[p] && snoop_hit[p])
          state_mem[bus.snoop_index[p]][snoop_way[p]] <= bus.snoop_state_in[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!busy) begin
      if (bus.cpu_write_tag) tag_mem[bus.cpu_index][cpu_way] <= bus.cpu_tag_in;
      if (bus.cpu_write_data) data_mem[bus.cpu_index][cpu_way][bus.cpu_offset] <= bus.cpu_data_in;
    end
  end

endmodule

// File: tb/tb_multi_snoop_cache_unit.sv
// Directed-vector bench for the snoopy cache store: lookups, LRU, conflicts, flush.
module tb_multi_snoop_cache_unit;
  import cache_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_snoop_cache_unit_if bus ();

  multi_snoop_cache_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_index         = '0;
    bus.cpu_offset        = '0;
    bus.cpu_tag_in        = '0;
    bus.cpu_data_in       = '0;
    bus.cpu_state_in      = '0;
    bus.cpu_write_tag     = 1'b0;
    bus.cpu_write_data    = 1'b0;
    bus.cpu_write_state   = 1'b0;
    bus.cpu_access        = 1'b0;
    bus.snoop_index       = '0;
    bus.snoop_offset      = '0;
    bus.snoop_tag_in      = '0;
    bus.snoop_state_in    = '0;
    bus.snoop_write_state = '0;
    bus.flush_request     = 1'b0;
  endtask

  task automatic cpu_lookup(input logic [5:0] idx, input logic [5:0] tag);
    bus.cpu_index  = idx;
    bus.cpu_tag_in = tag;
    bus.cpu_offset = '0;
    #1;
  endtask

  // Lookup, then write tag/word 0/state into the selected way and touch it.
  task automatic cpu_fill(input logic [5:0] idx, input logic [5:0] tag,
                          input logic [15:0] data, input logic [1:0] st);
    bus.cpu_index       = idx;
    bus.cpu_tag_in      = tag;
    bus.cpu_offset      = '0;
    bus.cpu_data_in     = data;
    bus.cpu_state_in    = st;
    bus.cpu_write_tag   = 1'b1;
    bus.cpu_write_data  = 1'b1;
    bus.cpu_write_state = 1'b1;
    bus.cpu_access      = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_flush();
    bus.flush_request = 1'b1;
    tick();
    bus.flush_request = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cpu_lookup(6'd5, 6'h2A);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got=%0h exp=0", bus.cpu_hit); end
    n_vec++; if (bus.cpu_cache_number !== 2'd0) begin n_err++; $display("FAIL reset_way got=%0d exp=0", bus.cpu_cache_number); end
    n_vec++; if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0h exp=0", bus.flush_busy); end
    n_vec++; if (bus.snoop_hit !== 2'b00) begin n_err++; $display("FAIL reset_snoop_hit got=%0b exp=00", bus.snoop_hit); end
  endtask

  task automatic test_basic_hit();
    cpu_fill(6'd5, 6'h2A, 16'h1234, 2'b01);
    cpu_lookup(6'd5, 6'h2A);
    n_vec++; if (bus.cpu_hit !== 1'b1) begin n_err++; $display("FAIL basic_hit got=%0h exp=1", bus.cpu_hit); end
    n_vec++; if (bus.cpu_cache_number !== 2'd0) begin n_err++; $display("FAIL basic_way got=%0d exp=0", bus.cpu_cache_number); end
    n_vec++; if (bus.cpu_data_out !== 16'h1234) begin n_err++; $display("FAIL basic_data got=%0h exp=1234", bus.cpu_data_out); end
    n_vec++; if (bus.cpu_state_out !== 2'b01) begin n_err++; $display("FAIL basic_state got=%0b exp=01", bus.cpu_state_out); end
    cpu_lookup(6'd5, 6'h15);
    n_vec++; if (bus.cpu_cache_number !== 2'd1) begin n_err++; $display("FAIL basic_next_invalid got=%0d exp=1", bus.cpu_cache_number); end
  endtask

  task automatic test_lru();
    for (int w = 0; w < 4; w++) begin
      cpu_lookup(6'd7, 6'(w + 1));
      n_vec++; if (bus.cpu_cache_number !== 2'(w)) begin n_err++; $display("FAIL lru_fill_way%0d got=%0d exp=%0d", w, bus.cpu_cache_number, w); end
      cpu_fill(6'd7, 6'(w + 1), 16'h1000 + 16'(w), 2'b01);
    end
    // ages now [3,2,1,0]; touching way 0 gives [0,3,2,1]
    cpu_lookup(6'd7, 6'd1);
    bus.cpu_access = 1'b1;
    tick();
    idle_inputs();
    cpu_lookup(6'd7, 6'h3F);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL lru_miss_hit got=%0h exp=0", bus.cpu_hit); end
    n_vec++; if (bus.cpu_cache_number !== 2'd1) begin n_err++; $display("FAIL lru_victim1 got=%0d exp=1", bus.cpu_cache_number); end
    // touching way 1 gives [1,0,3,2]
    cpu_lookup(6'd7, 6'd2);
    bus.cpu_access = 1'b1;
    tick();
    idle_inputs();
    cpu_lookup(6'd7, 6'h3F);
    n_vec++; if (bus.cpu_cache_number !== 2'd2) begin n_err++; $display("FAIL lru_victim2 got=%0d exp=2", bus.cpu_cache_number); end
  endtask

  task automatic test_snoop_conflict();
    bus.snoop_index[0]  = 6'd7;
    bus.snoop_tag_in[0] = 6'd4;
    #1;
    n_vec++; if (bus.snoop_hit[0] !== 1'b1) begin n_err++; $display("FAIL snoop0_hit got=%0h exp=1", bus.snoop_hit[0]); end
    n_vec++; if (bus.snoop_cache_number[0] !== 2'd3) begin n_err++; $display("FAIL snoop0_way got=%0d exp=3", bus.snoop_cache_number[0]); end
    n_vec++; if (bus.snoop_data_out[0] !== 16'h1003) begin n_err++; $display("FAIL snoop0_data got=%0h exp=1003", bus.snoop_data_out[0]); end
    idle_inputs();
    bus.cpu_index            = 6'd7;
    bus.cpu_tag_in           = 6'd3;
    bus.cpu_state_in         = 2'b11;
    bus.cpu_write_state      = 1'b1;
    bus.snoop_index[1]       = 6'd7;
    bus.snoop_tag_in[1]      = 6'd3;
    bus.snoop_state_in[1]    = 2'b00;
    bus.snoop_write_state    = 2'b10;
    #1;
    n_vec++; if (bus.snoop_cache_number[1] !== 2'd2) begin n_err++; $display("FAIL conflict_snoop_way got=%0d exp=2", bus.snoop_cache_number[1]); end
    n_vec++; if (bus.cpu_cache_number !== 2'd2) begin n_err++; $display("FAIL conflict_cpu_way got=%0d exp=2", bus.cpu_cache_number); end
    tick();
    idle_inputs();
    cpu_lookup(6'd7, 6'd3);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL conflict_after_hit got=%0h exp=0", bus.cpu_hit); end
    n_vec++; if (bus.cpu_cache_number !== 2'd2) begin n_err++; $display("FAIL conflict_after_way got=%0d exp=2", bus.cpu_cache_number); end
  endtask

  task automatic test_snoop_priority();
    cpu_fill(6'd3, 6'h0A, 16'h3000, 2'b01);
    cpu_fill(6'd3, 6'h0B, 16'h3001, 2'b01);
    bus.snoop_index       = {6'd3, 6'd3};
    bus.snoop_tag_in      = {6'h0B, 6'h0B};
    bus.snoop_state_in    = {2'b01, 2'b10};
    bus.snoop_write_state = 2'b11;
    tick();
    idle_inputs();
    cpu_lookup(6'd3, 6'h0B);
    n_vec++; if (bus.cpu_cache_number !== 2'd1) begin n_err++; $display("FAIL prio_way got=%0d exp=1", bus.cpu_cache_number); end
    n_vec++; if (bus.cpu_state_out !== 2'b10) begin n_err++; $display("FAIL prio_state got=%0b exp=10", bus.cpu_state_out); end
    // a snoop write that misses must leave the set alone
    bus.snoop_index[0]       = 6'd3;
    bus.snoop_tag_in[0]      = 6'h3C;
    bus.snoop_state_in[0]    = 2'b11;
    bus.snoop_write_state[0] = 1'b1;
    tick();
    idle_inputs();
    cpu_lookup(6'd3, 6'h0A);
    n_vec++; if (bus.cpu_state_out !== 2'b01) begin n_err++; $display("FAIL snoop_miss_write got=%0b exp=01", bus.cpu_state_out); end
  endtask

  task automatic test_flush();
    int busy_cycles;
    cpu_fill(6'd0, 6'h21, 16'hAAAA, 2'b01);
    cpu_fill(6'd63, 6'h22, 16'hBBBB, 2'b10);
    pulse_flush();
    cpu_lookup(6'd63, 6'h22);
    bus.snoop_index[0]  = 6'd63;
    bus.snoop_tag_in[0] = 6'h22;
    #1;
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL flush_cpu_hit_forced got=%0h exp=0", bus.cpu_hit); end
    n_vec++; if (bus.snoop_hit[0] !== 1'b1) begin n_err++; $display("FAIL flush_snoop_lookup got=%0h exp=1", bus.snoop_hit[0]); end
    idle_inputs();
    busy_cycles = 0;
    for (int c = 0; c < 200 && bus.flush_busy === 1'b1; c++) begin
      if (c == 10) begin
        bus.cpu_index       = 6'd0;
        bus.cpu_tag_in      = 6'h11;
        bus.cpu_data_in     = 16'h5A5A;
        bus.cpu_state_in    = 2'b01;
        bus.cpu_write_tag   = 1'b1;
        bus.cpu_write_data  = 1'b1;
        bus.cpu_write_state = 1'b1;
        bus.cpu_access      = 1'b1;
      end else if (c == 11) begin
        idle_inputs();
      end
      busy_cycles++;
      tick();
    end
    idle_inputs();
    n_vec++; if (busy_cycles != 64) begin n_err++; $display("FAIL flush_busy_len got=%0d exp=64", busy_cycles); end
    cpu_lookup(6'd0, 6'h11);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL flush_dropped_write got=%0h exp=0", bus.cpu_hit); end
    cpu_lookup(6'd0, 6'h21);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL flush_set0 got=%0h exp=0", bus.cpu_hit); end
    cpu_lookup(6'd63, 6'h22);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL flush_set63 got=%0h exp=0", bus.cpu_hit); end
    cpu_lookup(6'd7, 6'd1);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL flush_set7 got=%0h exp=0", bus.cpu_hit); end
    n_vec++; if (bus.cpu_cache_number !== 2'd0) begin n_err++; $display("FAIL flush_set7_victim got=%0d exp=0", bus.cpu_cache_number); end
  endtask

  task automatic test_reset_mid_flush();
    int busy_cycles;
    cpu_fill(6'd40, 6'h05, 16'h5555, 2'b01);
    cpu_lookup(6'd40, 6'h05);
    n_vec++; if (bus.cpu_hit !== 1'b1) begin n_err++; $display("FAIL rst_flush_pre_hit got=%0h exp=1", bus.cpu_hit); end
    idle_inputs();
    pulse_flush();
    repeat (10) tick();
    n_vec++; if (bus.flush_set !== 6'd10) begin n_err++; $display("FAIL rst_flush_counter got=%0d exp=10", bus.flush_set); end
    rst = 1'b1;
    #1;
    n_vec++; if (bus.flush_busy !== 1'b0) begin n_err++; $display("FAIL rst_flush_busy got=%0h exp=0", bus.flush_busy); end
    n_vec++; if (bus.flush_state !== IDLE) begin n_err++; $display("FAIL rst_flush_state got=%0d exp=0", bus.flush_state); end
    cpu_lookup(6'd40, 6'h05);
    n_vec++; if (bus.cpu_hit !== 1'b0) begin n_err++; $display("FAIL rst_flush_set40 got=%0h exp=0", bus.cpu_hit); end
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    pulse_flush();
    n_vec++; if (bus.flush_busy !== 1'b1) begin n_err++; $display("FAIL restart_busy got=%0h exp=1", bus.flush_busy); end
    n_vec++; if (bus.flush_set !== 6'd0) begin n_err++; $display("FAIL restart_set got=%0d exp=0", bus.flush_set); end
    busy_cycles = 0;
    for (int c = 0; c < 200 && bus.flush_busy === 1'b1; c++) begin
      busy_cycles++;
      tick();
    end
    n_vec++; if (busy_cycles != 64) begin n_err++; $display("FAIL restart_busy_len got=%0d exp=64", busy_cycles); end
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_lru();
    test_snoop_conflict();
    test_snoop_priority();
    test_flush();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
